// File: rtl/context_dispatch_ctrl_pkg.sv
// Shared types for the context dispatch controller: thread ids/contexts, the cache
// control word written back with each context, and the dispatch FSM states.
package context_dispatch_ctrl_pkg;

   localparam int ID_W  = 8;
   localparam int CTX_W = 32;

   typedef logic [ID_W-1:0]  thread_id_t;
   typedef logic [CTX_W-1:0] thread_register_union_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_CAPT     = 3'd2,
      ST_EXEC     = 3'd3,
      ST_WAIT_RES = 3'd4,
      ST_RET      = 3'd5
   } dispatch_state_t;

   typedef enum logic [1:0] {
      EXEC_NONE   = 2'd0,
      EXEC_LOCAL  = 2'd1,
      EXEC_REMOTE = 2'd2
   } execute_info_t;

   typedef enum logic [1:0] {
      NO_FORK       = 2'd0,
      FORK_ME_COPY  = 2'd1,
      FORK_ME_EMPTY = 2'd2
   } forking_info_t;

   typedef struct packed {
      logic          incoming;
      thread_id_t    incoming_id;
      logic          delete_thread;
      logic          sleep;
      execute_info_t execute_info;
      thread_id_t    execute_id;
      forking_info_t forking_info;
      thread_id_t    forking_id;
      logic          fork_sleep;
   } context_cache_control_t;

   // Disposition used when the execution unit never answers: park the thread asleep.
   localparam context_cache_control_t TMO_CTRL = '{
      incoming:      1'b0,
      incoming_id:   '0,
      delete_thread: 1'b0,
      sleep:         1'b1,
      execute_info:  EXEC_NONE,
      execute_id:    '0,
      forking_info:  NO_FORK,
      forking_id:    '0,
      fork_sleep:    1'b0
   };

endpackage

// File: rtl/context_dispatch_ctrl_sanitize.sv
// Cleans a disposition word before it reaches the cache so that fields made
// meaningless by other fields are forced to zero.
module context_dispatch_ctrl_sanitize
   import context_dispatch_ctrl_pkg::*;
(
   input  context_cache_control_t ctrl_raw,
   output context_cache_control_t ctrl_clean
);

   always_comb begin
      ctrl_clean = ctrl_raw;
      // A deleted thread can neither fork nor sleep.
      if (ctrl_raw.delete_thread) begin
         ctrl_clean.forking_info = NO_FORK;
         ctrl_clean.sleep        = 1'b0;
      end
      if (ctrl_clean.execute_info == EXEC_NONE) begin
         ctrl_clean.execute_id = '0;
      end
      if (ctrl_clean.forking_info == NO_FORK) begin
         ctrl_clean.forking_id = '0;
         ctrl_clean.fork_sleep = 1'b0;
      end
   end

endmodule

// File: rtl/context_dispatch_ctrl.sv
// Pulls one waiting thread from the context cache, runs it on an execution unit over
// valid/ready and writes the resulting context and disposition back to the cache.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | nothing in flight; start when the cache reports waiting work
//   REQ      | one-cycle pop request for held_id
//   CAPT     | wait out the cache latency, capture context, verify its id
//   EXEC     | offer the context to the execution unit
//   WAIT_RES | accept the result and its disposition
//   RET      | one-cycle write-back to the cache
module context_dispatch_ctrl
   import context_dispatch_ctrl_pkg::*;
#(
   parameter int REQ_LATENCY    = 1,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  thread_id_t             waiting_thread_count,
   input  thread_id_t             waiting_next_id,
   output logic                   requesting_thread,
   output thread_id_t             requested_thread_id,
   input  thread_register_union_t requested_thread_return,
   input  thread_id_t             out_thread_id,
   output context_cache_control_t incoming_control,
   output thread_register_union_t incoming_thread,
   output logic                   exec_valid,
   input  logic                   exec_ready,
   output thread_register_union_t exec_thread,
   output thread_id_t             exec_id,
   input  logic                   res_valid,
   output logic                   res_ready,
   input  thread_register_union_t res_thread,
   input  context_cache_control_t res_ctrl,
   output logic                   busy,
   output logic                   id_mismatch
);

   localparam int LAT_W = (REQ_LATENCY > 1) ? $clog2(REQ_LATENCY) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(REQ_LATENCY - 1);
   localparam logic [TMO_W-1:0] TMO_LOAD = (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

   dispatch_state_t        state, state_nxt;
   thread_id_t             held_id;
   thread_register_union_t held_thread;
   thread_register_union_t ret_thread;
   context_cache_control_t ret_ctrl;
   context_cache_control_t san_ctrl;
   logic [LAT_W-1:0]       lat_cnt;
   logic [TMO_W-1:0]       tmo_cnt;
   logic                   in_run;
   logic                   tmo_fire;
   logic                   ld_id, ld_ctx, ld_res, set_mismatch;

   assign busy     = (state != ST_IDLE);
   assign in_run   = (state == ST_EXEC) || (state == ST_WAIT_RES);
   assign tmo_fire = (TIMEOUT_CYCLES > 0) && in_run && (tmo_cnt == '0);

   context_dispatch_ctrl_sanitize u_sanitize (
      .ctrl_raw   (ret_ctrl),
      .ctrl_clean (san_ctrl)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt           = state;
      requesting_thread   = 1'b0;
      requested_thread_id = '0;
      exec_valid          = 1'b0;
      exec_thread         = '0;
      exec_id             = '0;
      res_ready           = 1'b0;
      incoming_control    = '0;
      incoming_thread     = '0;
      ld_id               = 1'b0;
      ld_ctx              = 1'b0;
      ld_res              = 1'b0;
      set_mismatch        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (waiting_thread_count != '0) begin
               ld_id     = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            requesting_thread   = 1'b1;
            requested_thread_id = held_id;
            state_nxt           = ST_CAPT;
         end
         ST_CAPT: begin
            if (lat_cnt == '0) begin
               if (out_thread_id != held_id) begin
                  set_mismatch = 1'b1;
                  state_nxt    = ST_IDLE;
               end else begin
                  ld_ctx    = 1'b1;
                  state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            exec_thread = held_thread;
            exec_id     = held_id;
            if (tmo_fire) begin
               state_nxt = ST_RET;
            end else begin
               exec_valid = 1'b1;
               if (exec_ready) state_nxt = ST_WAIT_RES;
            end
         end
         ST_WAIT_RES: begin
            if (tmo_fire) begin
               state_nxt = ST_RET;
            end else begin
               res_ready = 1'b1;
               if (res_valid) begin
                  ld_res    = 1'b1;
                  state_nxt = ST_RET;
               end
            end
         end
         ST_RET: begin
            // The cache slot is always the one we popped, whatever the unit reported.
            incoming_control             = san_ctrl;
            incoming_control.incoming    = 1'b1;
            incoming_control.incoming_id = held_id;
            incoming_thread              = ret_thread;
            state_nxt                    = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_id     <= '0;
         held_thread <= '0;
         ret_thread  <= '0;
         ret_ctrl    <= '0;
         lat_cnt     <= '0;
         tmo_cnt     <= '0;
         id_mismatch <= 1'b0;
      end else begin
         if (ld_id) held_id <= waiting_next_id;
         if (state == ST_REQ) begin
            lat_cnt <= LAT_LOAD;
         end else if ((state == ST_CAPT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (ld_ctx) begin
            held_thread <= requested_thread_return;
            tmo_cnt     <= TMO_LOAD;
         end else if (in_run && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
         if (set_mismatch) id_mismatch <= 1'b1;
         if (ld_res) begin
            ret_thread <= res_thread;
            ret_ctrl   <= res_ctrl;
         end else if (tmo_fire) begin
            ret_thread <= held_thread;
            ret_ctrl   <= TMO_CTRL;
         end
      end
   end

endmodule

// File: tb/tb_context_dispatch_ctrl.sv
// Directed bench for context_dispatch_ctrl: write-backs are predicted into a
// scoreboard when a dispatch is launched and compared when the DUT pulses incoming.
module tb_context_dispatch_ctrl;
   import context_dispatch_ctrl_pkg::*;

   typedef struct {
      string                  tag;
      thread_register_union_t thread;
      context_cache_control_t ctrl;
      int                     delta;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   thread_id_t             waiting_thread_count = '0;
   thread_id_t             waiting_next_id = '0;
   logic                   requesting_thread;
   thread_id_t             requested_thread_id;
   thread_register_union_t requested_thread_return = '0;
   thread_id_t             out_thread_id = '0;
   context_cache_control_t incoming_control;
   thread_register_union_t incoming_thread;
   logic                   exec_valid;
   logic                   exec_ready = 1'b0;
   thread_register_union_t exec_thread;
   thread_id_t             exec_id;
   logic                   res_valid = 1'b0;
   logic                   res_ready;
   thread_register_union_t res_thread = '0;
   context_cache_control_t res_ctrl = '0;
   logic                   busy;
   logic                   id_mismatch;

   int                     errors = 0;
   int                     checks = 0;
   int                     cyc = 0;
   int                     req_cyc = 0;
   logic                   req_d = 1'b0;
   thread_id_t             cur_id = '0;
   thread_id_t             cache_ret_id = '0;
   thread_register_union_t cache_ctx = '0;
   exp_t                   sb[$];

   context_dispatch_ctrl #(
      .REQ_LATENCY    (1),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .waiting_thread_count    (waiting_thread_count),
      .waiting_next_id         (waiting_next_id),
      .requesting_thread       (requesting_thread),
      .requested_thread_id     (requested_thread_id),
      .requested_thread_return (requested_thread_return),
      .out_thread_id           (out_thread_id),
      .incoming_control        (incoming_control),
      .incoming_thread         (incoming_thread),
      .exec_valid              (exec_valid),
      .exec_ready              (exec_ready),
      .exec_thread             (exec_thread),
      .exec_id                 (exec_id),
      .res_valid               (res_valid),
      .res_ready               (res_ready),
      .res_thread              (res_thread),
      .res_ctrl                (res_ctrl),
      .busy                    (busy),
      .id_mismatch             (id_mismatch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet_outputs(input string tag);
      check({tag, ".ctrl"}, 32'(incoming_control), 32'h0);
      check({tag, ".in_thread"}, incoming_thread, 32'h0);
      check({tag, ".exec_thread"}, exec_thread, 32'h0);
      check({tag, ".flags"}, 32'({requesting_thread, requested_thread_id, exec_valid,
                                  exec_id, res_ready, busy}), 32'h0);
   endtask

   // Cache model: context and id are valid only in the cycle after the pop request.
   always @(negedge clk) begin
      if (req_d) begin
         requested_thread_return = cache_ctx;
         out_thread_id           = cache_ret_id;
      end else begin
         requested_thread_return = 32'hDEAD_BEEF;
         out_thread_id           = 8'hEE;
      end
      req_d = requesting_thread;
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("req_and_incoming", 32'(requesting_thread & incoming_control.incoming), 32'h0);
         if (requesting_thread) req_cyc = cyc;
         if (exec_valid && exec_ready) begin
            check("exec_id", 32'(exec_id), 32'(cur_id));
            check("exec_thread", exec_thread, cache_ctx);
         end
         if (incoming_control.incoming) begin
            check("sb_entry", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check({e.tag, ".ctrl"}, 32'(incoming_control), 32'(e.ctrl));
               check({e.tag, ".thread"}, incoming_thread, e.thread);
               check({e.tag, ".latency"}, 32'(cyc - req_cyc), 32'(e.delta));
            end
         end
      end
   end

   task automatic dispatch(input string tag, input thread_id_t id, input thread_id_t ret_id,
                           input thread_register_union_t ctx);
      int n;
      cur_id               = id;
      cache_ret_id         = ret_id;
      cache_ctx            = ctx;
      waiting_next_id      = id;
      waiting_thread_count = 8'd1;
      n = 0;
      while (requesting_thread !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".req_seen"}, 32'(requesting_thread), 32'd1);
      check({tag, ".req_id"}, 32'(requested_thread_id), 32'(id));
      waiting_thread_count = '0;
      waiting_next_id      = 8'hFF;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".back_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   n;

      // Reset values
      #2;
      check_quiet_outputs("reset");
      check("reset.mismatch", 32'(id_mismatch), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1: nothing waiting
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t1.idle_flags", 32'({requesting_thread, busy, exec_valid, res_ready,
                                     incoming_control.incoming}), 32'h0);
      end
      check_quiet_outputs("t1");

      // 2: plain run, unused control fields must be zeroed
      exec_ready = 1'b1;
      res_valid  = 1'b1;
      res_thread = 32'hA5A5_0002;
      res_ctrl   = '0;
      res_ctrl.incoming    = 1'b1;
      res_ctrl.incoming_id = 8'h55;
      res_ctrl.execute_id  = 8'd9;
      res_ctrl.forking_id  = 8'd6;
      res_ctrl.fork_sleep  = 1'b1;
      e.tag = "t2"; e.thread = 32'hA5A5_0002; e.delta = 4;
      e.ctrl = '0; e.ctrl.incoming = 1'b1; e.ctrl.incoming_id = 8'd2;
      sb.push_back(e);
      dispatch("t2", 8'd2, 8'd2, 32'h1111_0002);

      // 3: delete overrides fork and sleep
      res_thread = 32'hC0DE_0003;
      res_ctrl   = '0;
      res_ctrl.incoming_id   = 8'h77;
      res_ctrl.delete_thread = 1'b1;
      res_ctrl.sleep         = 1'b1;
      res_ctrl.execute_info  = EXEC_LOCAL;
      res_ctrl.execute_id    = 8'd4;
      res_ctrl.forking_info  = FORK_ME_COPY;
      res_ctrl.forking_id    = 8'd3;
      res_ctrl.fork_sleep    = 1'b1;
      e.tag = "t3"; e.thread = 32'hC0DE_0003; e.delta = 4;
      e.ctrl = '0; e.ctrl.incoming = 1'b1; e.ctrl.incoming_id = 8'd3;
      e.ctrl.delete_thread = 1'b1; e.ctrl.execute_info = EXEC_LOCAL; e.ctrl.execute_id = 8'd4;
      sb.push_back(e);
      dispatch("t3", 8'd3, 8'd3, 32'h2222_0003);
      check("t3.mismatch", 32'(id_mismatch), 32'd0);

      // 4: cache returns the wrong id, thread is dropped
      dispatch("t4", 8'd4, 8'd5, 32'h3333_0004);
      check("t4.mismatch", 32'(id_mismatch), 32'd1);

      // 5: execution unit never accepts, timeout parks the original context
      exec_ready = 1'b0;
      res_valid  = 1'b1;
      res_thread = 32'hBAD0_BAD0;
      res_ctrl   = '0;
      res_ctrl.delete_thread = 1'b1;
      e.tag = "t5"; e.thread = 32'h4444_0006; e.delta = 10;
      e.ctrl = '0; e.ctrl.incoming = 1'b1; e.ctrl.incoming_id = 8'd6; e.ctrl.sleep = 1'b1;
      sb.push_back(e);
      dispatch("t5", 8'd6, 8'd6, 32'h4444_0006);
      check("t5.mismatch_sticky", 32'(id_mismatch), 32'd1);

      // 6: reset while waiting for the result
      exec_ready           = 1'b1;
      res_valid            = 1'b0;
      cur_id               = 8'd7;
      cache_ret_id         = 8'd7;
      cache_ctx            = 32'h5555_0007;
      waiting_next_id      = 8'd7;
      waiting_thread_count = 8'd1;
      n = 0;
      while (res_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6.in_wait_res", 32'(res_ready), 32'd1);
      waiting_thread_count = '0;
      rst = 1'b1;
      #1;
      check_quiet_outputs("t6.async");
      check("t6.mismatch_cleared", 32'(id_mismatch), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t6.idle_after", 32'({busy, requesting_thread}), 32'h0);

      // 7: normal operation resumes after reset
      res_valid  = 1'b1;
      res_thread = 32'h6666_0001;
      res_ctrl   = '0;
      res_ctrl.execute_info = EXEC_REMOTE;
      res_ctrl.execute_id   = 8'd12;
      res_ctrl.forking_info = FORK_ME_EMPTY;
      res_ctrl.forking_id   = 8'd13;
      res_ctrl.fork_sleep   = 1'b1;
      e.tag = "t7"; e.thread = 32'h6666_0001; e.delta = 4;
      e.ctrl = res_ctrl; e.ctrl.incoming = 1'b1; e.ctrl.incoming_id = 8'd1;
      sb.push_back(e);
      dispatch("t7", 8'd1, 8'd1, 32'h7777_0001);

      repeat (2) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
